// File: rtl/hdc_dispatch_pkg.sv
// hdc_dispatch_pkg: types shared by the bind command dispatcher and its command FIFO.
// bind_cmd_t field width is fixed here at BIND_ADDR_WIDTH; the dispatcher resizes
// its HV_ADDRESS_WIDTH ports to this width, so keep the two equal when reconfiguring.
package hdc_dispatch_pkg;

    localparam int BIND_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [BIND_ADDR_WIDTH-1:0] vec_length;
        logic [BIND_ADDR_WIDTH-1:0] hva;
        logic [BIND_ADDR_WIDTH-1:0] hvb;
        logic [BIND_ADDR_WIDTH-1:0] hvc;
    } bind_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } dispatch_state_t;

    // Two windows [x, x+span) and [y, y+span) intersect when each starts before the other ends.
    function automatic logic windows_overlap(input int unsigned base_x,
                                             input int unsigned base_y,
                                             input int unsigned span);
        return (base_x < base_y + span) && (base_y < base_x + span);
    endfunction

endpackage

// File: rtl/bind_cmd_fifo.sv
// bind_cmd_fifo: power-of-two deep FIFO of bind commands with wrapping pointers.
// A push while full or a pop while empty is ignored; push and pop may share a cycle.
module bind_cmd_fifo
    import hdc_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  bind_cmd_t push_data,
    input  logic      pop,
    output bind_cmd_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_COUNT = (PTR_W+1)'(DEPTH);

    bind_cmd_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == DEPTH_COUNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; occupancy is unchanged by a simultaneous push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/bind_command_dispatcher.sv
// bind_command_dispatcher: queues bind commands and issues them one at a time to the
// bind kernel mapper with a level valid / rising-edge done handshake.
// Optional feature: define BIND_DISPATCH_OVERLAP_CHECK_EN to reject commands whose
// destination window overlaps either source window (err_overlap); otherwise err_overlap is 0.
module bind_command_dispatcher
    import hdc_dispatch_pkg::*;
#(
    parameter int HV_ADDRESS_WIDTH       = 5,
    parameter int MAX_HYPERVECTOR_LENGTH = 4,
    parameter int QUEUE_DEPTH            = 4
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_vec_length,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hva,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvb,
    input  logic [HV_ADDRESS_WIDTH-1:0] cmd_hvc,
    output logic                        bk_valid,
    output logic [HV_ADDRESS_WIDTH-1:0] bk_vec_length,
    output logic [HV_ADDRESS_WIDTH-1:0] bk_hva,
    output logic [HV_ADDRESS_WIDTH-1:0] bk_hvb,
    output logic [HV_ADDRESS_WIDTH-1:0] bk_hvc,
    input  logic                        bk_done,
    output logic                        busy,
    output logic [7:0]                  completed_count,
    output logic                        err_len,
    output logic                        err_overlap
);

    localparam logic [HV_ADDRESS_WIDTH-1:0] MAX_LEN = HV_ADDRESS_WIDTH'(MAX_HYPERVECTOR_LENGTH);

    dispatch_state_t state;
    bind_cmd_t       incoming;
    bind_cmd_t       fifo_head;
    bind_cmd_t       bk_cmd;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            len_bad;
    logic            overlap_bad;
    logic            push;
    logic            pop;
    logic            bk_done_q;

    assign incoming.vec_length = BIND_ADDR_WIDTH'(cmd_vec_length);
    assign incoming.hva        = BIND_ADDR_WIDTH'(cmd_hva);
    assign incoming.hvb        = BIND_ADDR_WIDTH'(cmd_hvb);
    assign incoming.hvc        = BIND_ADDR_WIDTH'(cmd_hvc);

    // No bypass path: a full queue refuses input even in a cycle that pops.
    assign cmd_ready = !reset && !fifo_full;
    assign accept    = cmd_valid && cmd_ready;
    assign len_bad   = (cmd_vec_length == '0) || (cmd_vec_length > MAX_LEN);

`ifdef BIND_DISPATCH_OVERLAP_CHECK_EN
    localparam int unsigned SPAN = MAX_HYPERVECTOR_LENGTH;

    assign overlap_bad = windows_overlap(32'(cmd_hvc), 32'(cmd_hva), SPAN) ||
                         windows_overlap(32'(cmd_hvc), 32'(cmd_hvb), SPAN);

    // Overlap rejections are sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overlap <= 1'b0;
        end else if (accept && overlap_bad) begin
            err_overlap <= 1'b1;
        end
    end
`else
    assign overlap_bad = 1'b0;
    assign err_overlap = 1'b0;
`endif

    assign push = accept && !len_bad && !overlap_bad;
    assign pop  = (state == ST_IDLE) && !fifo_empty;

    bind_cmd_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (incoming),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Length rejections are sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_len <= 1'b0;
        end else if (accept && len_bad) begin
            err_len <= 1'b1;
        end
    end

    // Delayed copy of bk_done so only its rising edge counts as a completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            bk_done_q <= 1'b0;
        end else begin
            bk_done_q <= bk_done;
        end
    end

    // Issue FSM: pop into the bk_* registers, hold until done rises, then wait for done to drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            bk_valid        <= 1'b0;
            bk_cmd          <= '0;
            completed_count <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        bk_cmd   <= fifo_head;
                        bk_valid <= 1'b1;
                        state    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (bk_done && !bk_done_q) begin
                        bk_valid        <= 1'b0;
                        completed_count <= completed_count + 8'd1;
                        state           <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!bk_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    bk_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bk_vec_length = HV_ADDRESS_WIDTH'(bk_cmd.vec_length);
    assign bk_hva        = HV_ADDRESS_WIDTH'(bk_cmd.hva);
    assign bk_hvb        = HV_ADDRESS_WIDTH'(bk_cmd.hvb);
    assign bk_hvc        = HV_ADDRESS_WIDTH'(bk_cmd.hvc);

    // A command still finishing its handshake (RELEASE) keeps the block busy.
    assign busy = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_bind_command_dispatcher.sv
// tb_bind_command_dispatcher: table-driven vectors, directed multi-cycle sequences and
// randomized traffic checked against a queue-based reference model.
// Honors BIND_DISPATCH_OVERLAP_CHECK_EN so expectations follow the build being tested.
`timescale 1ns/1ps
module tb_bind_command_dispatcher;

    localparam int AW     = 5;
    localparam int MAXLEN = 4;
    localparam int DEPTH  = 4;
`ifdef BIND_DISPATCH_OVERLAP_CHECK_EN
    localparam bit OVL_ON = 1'b1;
`else
    localparam bit OVL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_vec_length = '0;
    logic [AW-1:0] cmd_hva = '0;
    logic [AW-1:0] cmd_hvb = '0;
    logic [AW-1:0] cmd_hvc = '0;
    logic          bk_done = 1'b0;
    logic          cmd_ready;
    logic          bk_valid;
    logic [AW-1:0] bk_vec_length;
    logic [AW-1:0] bk_hva;
    logic [AW-1:0] bk_hvb;
    logic [AW-1:0] bk_hvc;
    logic          busy;
    logic [7:0]    completed_count;
    logic          err_len;
    logic          err_overlap;

    always #5 clk = ~clk;

    bind_command_dispatcher #(
        .HV_ADDRESS_WIDTH       (AW),
        .MAX_HYPERVECTOR_LENGTH (MAXLEN),
        .QUEUE_DEPTH            (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_vec_length  (cmd_vec_length),
        .cmd_hva         (cmd_hva),
        .cmd_hvb         (cmd_hvb),
        .cmd_hvc         (cmd_hvc),
        .bk_valid        (bk_valid),
        .bk_vec_length   (bk_vec_length),
        .bk_hva          (bk_hva),
        .bk_hvb          (bk_hvb),
        .bk_hvc          (bk_hvc),
        .bk_done         (bk_done),
        .busy            (busy),
        .completed_count (completed_count),
        .err_len         (err_len),
        .err_overlap     (err_overlap)
    );

    typedef struct packed {
        logic [AW-1:0] len;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
    } tb_cmd_t;

    typedef struct {
        bit            rst;
        bit            valid;
        logic [AW-1:0] len;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
        bit            done;
        bit            e_valid;
        bit            e_busy;
        bit            e_ready;
        int            e_count;
        bit            e_err_len;
        bit            e_err_ovl;
        logic [19:0]   e_fields;
    } vec_t;

    localparam int NROWS = 14;
    vec_t tbl [NROWS];

    // Reference model: a plain queue of waiting commands plus the command being serviced.
    tb_cmd_t m_q[$];
    tb_cmd_t m_cur = '0;
    bit      m_inflight = 1'b0;
    bit      m_await_low = 1'b0;
    bit      m_done_prev = 1'b0;
    bit      m_err_len = 1'b0;
    bit      m_err_ovl = 1'b0;
    int      m_count = 0;

    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(bit rst, bit valid, int len, int a, int b, int c, bit done,
                                bit e_valid, bit e_busy, bit e_ready, int e_count,
                                bit e_err_len, bit e_err_ovl, logic [19:0] e_fields);
        vec_t v;
        v.rst = rst; v.valid = valid;
        v.len = AW'(len); v.a = AW'(a); v.b = AW'(b); v.c = AW'(c);
        v.done = done; v.e_valid = e_valid; v.e_busy = e_busy; v.e_ready = e_ready;
        v.e_count = e_count; v.e_err_len = e_err_len; v.e_err_ovl = e_err_ovl;
        v.e_fields = e_fields;
        return v;
    endfunction

    // Destination collides with a source when any word address of one equals any of the other.
    function automatic bit model_overlap(tb_cmd_t cmd);
        for (int i = 0; i < MAXLEN; i++) begin
            for (int j = 0; j < MAXLEN; j++) begin
                if (int'(cmd.c) + i == int'(cmd.a) + j) return 1'b1;
                if (int'(cmd.c) + i == int'(cmd.b) + j) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic modelStep();
        tb_cmd_t incoming;
        bit      ready;
        bit      can_pop;
        bit      len_bad;
        bit      ovl_bad;
        if (reset) begin
            m_q.delete();
            m_cur = '0;
            m_inflight = 1'b0;
            m_await_low = 1'b0;
            m_done_prev = 1'b0;
            m_err_len = 1'b0;
            m_err_ovl = 1'b0;
            m_count = 0;
            return;
        end
        ready   = m_q.size() < DEPTH;
        can_pop = !m_inflight && !m_await_low && (m_q.size() > 0);
        if (m_inflight && bk_done && !m_done_prev) begin
            m_inflight  = 1'b0;
            m_await_low = 1'b1;
            m_count     = (m_count + 1) % 256;
        end else if (m_await_low && !bk_done) begin
            m_await_low = 1'b0;
        end
        if (can_pop) begin
            m_cur = m_q.pop_front();
            m_inflight = 1'b1;
        end
        if (cmd_valid && ready) begin
            incoming = {cmd_vec_length, cmd_hva, cmd_hvb, cmd_hvc};
            len_bad = (int'(incoming.len) == 0) || (int'(incoming.len) > MAXLEN);
            ovl_bad = OVL_ON && model_overlap(incoming);
            if (len_bad) m_err_len = 1'b1;
            if (ovl_bad) m_err_ovl = 1'b1;
            if (!len_bad && !ovl_bad) m_q.push_back(incoming);
        end
        m_done_prev = bk_done;
    endtask

    task automatic applyStimulus(input bit rst, input bit valid, input logic [AW-1:0] len,
                                 input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic [AW-1:0] c, input bit done);
        reset = rst;
        cmd_valid = valid;
        cmd_vec_length = len;
        cmd_hva = a;
        cmd_hvb = b;
        cmd_hvc = c;
        bk_done = done;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, "_cmd_ready"}, cmd_ready, (!reset && m_q.size() < DEPTH));
        compare({tag, "_bk_valid"}, bk_valid, m_inflight);
        compare({tag, "_bk_fields"}, {bk_vec_length, bk_hva, bk_hvb, bk_hvc}, m_cur);
        compare({tag, "_busy"}, busy, (m_q.size() > 0) || m_inflight || m_await_low);
        compare({tag, "_count"}, completed_count, m_count);
        compare({tag, "_err_len"}, err_len, m_err_len);
        compare({tag, "_err_overlap"}, err_overlap, m_err_ovl);
    endtask

    initial begin
        logic [19:0] f1;
        logic [19:0] f2;
        f1 = {5'd4, 5'd0, 5'd4, 5'd8};
        f2 = {5'd4, 5'd0, 5'd8, 5'd2};

        // Reset, single command latency and handshake, length errors, overlap-sensitive command.
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, '0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, '0);
        tbl[2]  = mk(0, 1, 4, 0, 4, 8, 0,  0, 1, 1, 0, 0, 0, '0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, f1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, f1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 1, 0, 0, '0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, '0);
        tbl[7]  = mk(0, 1, 0, 0, 4, 8, 0,  0, 0, 1, 1, 1, 0, '0);
        tbl[8]  = mk(0, 1, 5, 0, 4, 8, 0,  0, 0, 1, 1, 1, 0, '0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0, '0);
        tbl[10] = mk(0, 1, 4, 0, 8, 2, 0,  0, !OVL_ON, 1, 1, 1, OVL_ON, '0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,  !OVL_ON, !OVL_ON, 1, 1, 1, OVL_ON, f2);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1,  0, !OVL_ON, 1, OVL_ON ? 1 : 2, 1, OVL_ON, '0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, OVL_ON ? 1 : 2, 1, OVL_ON, '0);

        for (int i = 0; i < NROWS; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].len, tbl[i].a, tbl[i].b,
                          tbl[i].c, tbl[i].done);
            compare($sformatf("row%0d_bk_valid", i), bk_valid, tbl[i].e_valid);
            compare($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
            compare($sformatf("row%0d_cmd_ready", i), cmd_ready, tbl[i].e_ready);
            compare($sformatf("row%0d_count", i), completed_count, tbl[i].e_count);
            compare($sformatf("row%0d_err_len", i), err_len, tbl[i].e_err_len);
            compare($sformatf("row%0d_err_overlap", i), err_overlap, tbl[i].e_err_ovl);
            if (tbl[i].e_valid) begin
                compare($sformatf("row%0d_fields", i),
                        {bk_vec_length, bk_hva, bk_hvb, bk_hvc}, tbl[i].e_fields);
            end
        end

        // Five back-to-back pushes fill the queue behind one in-flight command.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("s37_reset");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 4, 0, 4, AW'(8 + 4 * k), 0);
            checkOutput("s37_push");
        end
        compare("s37_ready_full", cmd_ready, 0);
        for (int k = 0; k < 5; k++) begin
            compare($sformatf("s37_order%0d", k), bk_hvc, 8 + 4 * k);
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            checkOutput("s37_done");
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checkOutput("s37_release");
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checkOutput("s37_next");
        end
        compare("s37_count", completed_count, 5);

        // bk_done held high for three cycles counts once and blocks the next issue.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 4, 0, 4, 8, 0);
        applyStimulus(0, 1, 4, 0, 4, 12, 0);
        checkOutput("s39_active");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            checkOutput("s39_hold");
            compare("s39_hold_valid", bk_valid, 0);
        end
        compare("s39_count_once", completed_count, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        compare("s39_fall_valid", bk_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        compare("s39_next_valid", bk_valid, 1);
        compare("s39_next_hvc", bk_hvc, 12);
        checkOutput("s39_next");

        // Reset while a command is in flight with two more queued.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 4, 0, 4, 8, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        compare("s41_pre_count", completed_count, 1);
        applyStimulus(0, 1, 4, 0, 4, 12, 0);
        applyStimulus(0, 1, 4, 0, 4, 16, 0);
        applyStimulus(0, 1, 4, 0, 4, 20, 0);
        checkOutput("s41_loaded");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        compare("s41_bk_valid", bk_valid, 0);
        compare("s41_busy", busy, 0);
        compare("s41_count", completed_count, 0);
        compare("s41_ready", cmd_ready, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("s41_after");

        // Randomized traffic with occasional resets, checked every cycle against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 5)),
                          AW'($urandom_range(0, 31)),
                          AW'($urandom_range(0, 31)),
                          AW'($urandom_range(0, 31)),
                          $urandom_range(0, 9) < 3);
            checkOutput("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
